// File: rtl/cv32e40p_tmr_pkg.sv
// Shared types for the TMR recovery controller.
// Replica vectors, FSM state encoding and a popcount helper.
package cv32e40p_tmr_pkg;

    localparam int N_REPLICAS = 3;

    typedef logic [2:0] replica_vec_t;

    typedef enum logic [1:0] {
        IDLE,
        HALT,
        RESYNC,
        FATAL
    } tmr_rec_state_e;

    function automatic logic [1:0] popcnt3(input replica_vec_t v);
        return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    endfunction

endpackage

// File: rtl/cv32e40p_tmr_fault_cnt.sv
// Per-replica leaky fault counter (4-bit, saturating).
// o_retire flags that this increment reaches the retirement threshold.
module cv32e40p_tmr_fault_cnt
    import cv32e40p_tmr_pkg::*;
#(
    parameter int FAULT_THRESHOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_leak,
    output logic o_retire
);

    logic [3:0] r_cnt;
    logic [3:0] w_inc_val;

    assign w_inc_val = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
    assign o_retire  = i_inc && (w_inc_val == 4'(FAULT_THRESHOLD));

    // Count up on a fault, down on a window wrap; both together cancel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (i_inc && !i_leak) begin
            r_cnt <= w_inc_val;
        end else if (!i_inc && i_leak && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

endmodule

// File: rtl/cv32e40p_tmr_recovery_ctrl.sv
// TMR recovery controller: halt, resync, retire, fatal.
// Optional error log port enabled by CV32E40P_TMR_ERR_LOG_EN.
module cv32e40p_tmr_recovery_ctrl
    import cv32e40p_tmr_pkg::*;
#(
    parameter int RESYNC_CYCLES   = 8,
    parameter int FAULT_THRESHOLD = 4,
    parameter int WINDOW_CYCLES   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  mismatch_i,
    input  logic        all_diff_i,
    input  logic        halt_ack_i,
    output logic        halt_req_o,
    output logic        resync_o,
    output logic [2:0]  resync_sel_o,
    output logic [2:0]  replica_en_o,
    output logic        degraded_o,
    output logic        fatal_o,
    output logic        busy_o
`ifdef CV32E40P_TMR_ERR_LOG_EN
    ,
    output logic [47:0] err_log_o
`endif
);

    localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [7:0] RC_M1 = 8'(RESYNC_CYCLES - 1);

    tmr_rec_state_e r_state;
    logic [WIN_W-1:0] r_win;
    logic [7:0] r_cnt;
    replica_vec_t r_sel;
    replica_vec_t r_rsel;
    replica_vec_t r_en;
    logic r_halt;
    logic r_resync;
    logic r_deg;
    logic r_fatal;
    logic r_busy;

    logic w_wrap;
    replica_vec_t w_eff;
    logic [1:0] w_pop;
    logic w_fatal_idle;
    logic w_accept;
    replica_vec_t w_inc;
    replica_vec_t w_retire;
    logic w_any_retire;

    assign w_wrap       = (r_win == WIN_LAST);
    assign w_eff        = mismatch_i & r_en;
    assign w_pop        = popcnt3(w_eff);
    assign w_fatal_idle = all_diff_i || (w_pop >= 2'd2) || (r_deg && (w_eff != 3'b000));
    assign w_accept     = (r_state == IDLE) && !w_fatal_idle && (w_pop == 2'd1);
    assign w_inc        = w_accept ? w_eff : 3'b000;
    assign w_any_retire = |w_retire;

    // Free-running leak window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win <= '0;
        end else if (w_wrap) begin
            r_win <= '0;
        end else begin
            r_win <= r_win + 1'b1;
        end
    end

    for (genvar g = 0; g < N_REPLICAS; g++) begin : g_cnt
        cv32e40p_tmr_fault_cnt #(
            .FAULT_THRESHOLD(FAULT_THRESHOLD)
        ) u_fault_cnt (
            .clk     (clk),
            .rst     (rst),
            .i_inc   (w_inc[g]),
            .i_leak  (w_wrap),
            .o_retire(w_retire[g])
        );
    end

    // Recovery FSM; outputs are registered alongside the state.
    // FATAL keeps only halt and fatal asserted, busy included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= 8'd0;
            r_sel    <= 3'b000;
            r_rsel   <= 3'b000;
            r_en     <= 3'b111;
            r_halt   <= 1'b0;
            r_resync <= 1'b0;
            r_deg    <= 1'b0;
            r_fatal  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_fatal_idle) begin
                        r_state <= FATAL;
                        r_halt  <= 1'b1;
                        r_fatal <= 1'b1;
                    end else if (w_accept) begin
                        r_sel <= w_eff;
                        if (w_any_retire) begin
                            r_en  <= r_en & ~w_eff;
                            r_deg <= 1'b1;
                        end else begin
                            r_state <= HALT;
                            r_halt  <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    if (all_diff_i) begin
                        r_state <= FATAL;
                        r_fatal <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (halt_ack_i) begin
                        r_state  <= RESYNC;
                        r_cnt    <= RC_M1;
                        r_resync <= 1'b1;
                        r_rsel   <= r_sel;
                    end
                end
                RESYNC: begin
                    if (all_diff_i) begin
                        r_state  <= FATAL;
                        r_fatal  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_resync <= 1'b0;
                        r_rsel   <= 3'b000;
                    end else if (r_cnt == 8'd0) begin
                        r_state  <= IDLE;
                        r_halt   <= 1'b0;
                        r_busy   <= 1'b0;
                        r_resync <= 1'b0;
                        r_rsel   <= 3'b000;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                FATAL: begin
                    r_state <= FATAL;
                end
            endcase
        end
    end

    assign halt_req_o   = r_halt;
    assign resync_o     = r_resync;
    assign resync_sel_o = r_rsel;
    assign replica_en_o = r_en;
    assign degraded_o   = r_deg;
    assign fatal_o      = r_fatal;
    assign busy_o       = r_busy;

`ifdef CV32E40P_TMR_ERR_LOG_EN
    logic [15:0] r_tot_corr;
    logic [15:0] r_fatal_cyc;

    // Saturating statistics for corrected events and fatal dwell time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tot_corr  <= 16'd0;
            r_fatal_cyc <= 16'd0;
        end else begin
            if (w_accept && !w_any_retire && (r_tot_corr != 16'hFFFF)) begin
                r_tot_corr <= r_tot_corr + 16'd1;
            end
            if ((r_state == FATAL) && (r_fatal_cyc != 16'hFFFF)) begin
                r_fatal_cyc <= r_fatal_cyc + 16'd1;
            end
        end
    end

    assign err_log_o = {r_tot_corr, r_sel, 13'b0, r_fatal_cyc};
`endif

endmodule

// File: tb/tb_cv32e40p_tmr_recovery_ctrl.sv
// Self-checking bench for cv32e40p_tmr_recovery_ctrl.
// Directed scenarios plus random traffic against a behavioural model.
module tb_cv32e40p_tmr_recovery_ctrl;

    localparam int RC  = 8;
    localparam int TH  = 4;
    localparam int WIN = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] mismatch_i = 3'b000;
    logic all_diff_i = 1'b0;
    logic halt_ack_i = 1'b0;
    logic halt_req_o, resync_o, degraded_o, fatal_o, busy_o;
    logic [2:0] resync_sel_o, replica_en_o;
`ifdef CV32E40P_TMR_ERR_LOG_EN
    logic [47:0] err_log_o;
`endif

    cv32e40p_tmr_recovery_ctrl #(
        .RESYNC_CYCLES(RC),
        .FAULT_THRESHOLD(TH),
        .WINDOW_CYCLES(WIN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mismatch_i(mismatch_i),
        .all_diff_i(all_diff_i),
        .halt_ack_i(halt_ack_i),
        .halt_req_o(halt_req_o),
        .resync_o(resync_o),
        .resync_sel_o(resync_sel_o),
        .replica_en_o(replica_en_o),
        .degraded_o(degraded_o),
        .fatal_o(fatal_o),
        .busy_o(busy_o)
`ifdef CV32E40P_TMR_ERR_LOG_EN
        ,
        .err_log_o(err_log_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: mode 0 idle, 1 halted, 2 resyncing, 3 fatal.
    int m_mode;
    int m_cnt[3];
    int m_rem;
    int m_win;
    int m_corr;
    int m_fcyc;
    logic [2:0] m_en;
    logic [2:0] m_sel;
    logic m_deg;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] dut_out();
        return {halt_req_o, resync_o, resync_sel_o, replica_en_o,
                degraded_o, fatal_o, busy_o};
    endfunction

    function automatic logic [10:0] exp_out();
        logic rs;
        rs = (m_mode == 2);
        return {m_mode != 0, rs, rs ? m_sel : 3'b000, m_en,
                m_deg, m_mode == 3, (m_mode == 1) || (m_mode == 2)};
    endfunction

    function automatic logic [47:0] exp_log();
        return {16'(m_corr), m_sel, 13'b0, 16'(m_fcyc)};
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_rem = 0;
        m_win = 0;
        m_corr = 0;
        m_fcyc = 0;
        m_en = 3'b111;
        m_sel = 3'b000;
        m_deg = 1'b0;
        for (int j = 0; j < 3; j++) m_cnt[j] = 0;
    endtask

    task automatic model_step(input logic [2:0] mm, input logic ad, input logic ack);
        bit wrap;
        logic [2:0] eff;
        int n;
        int k;
        int nc;
        wrap = (m_win == WIN - 1);
        m_win = wrap ? 0 : m_win + 1;
        eff = mm & m_en;
        n = $countones(eff);
        k = -1;
        if (m_mode == 3 && m_fcyc < 65535) m_fcyc++;
        case (m_mode)
            0: begin
                if (ad || n >= 2 || (m_deg && n != 0)) begin
                    m_mode = 3;
                end else if (n == 1) begin
                    k = eff[0] ? 0 : (eff[1] ? 1 : 2);
                    m_sel = eff;
                    nc = (m_cnt[k] < 15) ? m_cnt[k] + 1 : 15;
                    if (!wrap) m_cnt[k] = nc;
                    if (nc == TH) begin
                        m_en = m_en & ~eff;
                        m_deg = 1'b1;
                    end else begin
                        m_mode = 1;
                        if (m_corr < 65535) m_corr++;
                    end
                end
            end
            1: begin
                if (ad) m_mode = 3;
                else if (ack) begin
                    m_mode = 2;
                    m_rem = RC;
                end
            end
            2: begin
                if (ad) m_mode = 3;
                else begin
                    m_rem--;
                    if (m_rem == 0) m_mode = 0;
                end
            end
            default: ;
        endcase
        for (int j = 0; j < 3; j++)
            if (j != k && wrap && m_cnt[j] > 0) m_cnt[j]--;
    endtask

    task automatic cyc(input string tag, input logic [2:0] mm, input logic ad, input logic ack);
        @(negedge clk);
        mismatch_i = mm;
        all_diff_i = ad;
        halt_ack_i = ack;
        @(posedge clk);
        model_step(mm, ad, ack);
        #1;
        chk(tag, 64'(dut_out()), 64'(exp_out()));
`ifdef CV32E40P_TMR_ERR_LOG_EN
        chk({tag, "_log"}, 64'(err_log_o), 64'(exp_log()));
`endif
    endtask

    // Asserts rst between edges and checks outputs clear immediately.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_out", 64'(dut_out()), 64'(exp_out()));
        chk("rst_en", 64'(replica_en_o), 64'(3'b111));
`ifdef CV32E40P_TMR_ERR_LOG_EN
        chk("rst_log", 64'(err_log_o), 64'd0);
`endif
        mismatch_i = 3'b000;
        all_diff_i = 1'b0;
        halt_ack_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic recover(input string tag, input logic [2:0] mm);
        cyc(tag, mm, 1'b0, 1'b0);
        cyc(tag, 3'b000, 1'b0, 1'b1);
        repeat (RC + 1) cyc(tag, 3'b000, 1'b0, 1'b0);
    endtask

    initial begin
        int n;
        int r;
        logic [2:0] mm;
        model_reset();
        #12;
        do_reset();

        // Single fault on replica 1, ack on the third halted cycle.
        cyc("t1_mm", 3'b010, 1'b0, 1'b0);
        chk("t1_halt", 64'(halt_req_o), 64'd1);
        repeat (2) cyc("t1_wait", 3'b000, 1'b0, 1'b0);
        cyc("t1_ack", 3'b000, 1'b0, 1'b1);
        chk("t1_sel", 64'(resync_sel_o), 64'(3'b010));
        n = resync_o ? 1 : 0;
        for (int i = 0; i < 20 && resync_o; i++) begin
            cyc("t1_rs", 3'b000, 1'b0, 1'b0);
            if (resync_o) n++;
        end
        chk("t1_len", 64'(n), 64'(RC));
        chk("t1_busy", 64'(busy_o), 64'd0);
        chk("t1_hrq", 64'(halt_req_o), 64'd0);

        // Four faults on replica 0 retire it.
        do_reset();
        repeat (3) recover("t2", 3'b001);
        chk("t2_en3", 64'(replica_en_o), 64'(3'b111));
        cyc("t2_4th", 3'b001, 1'b0, 1'b0);
        chk("t2_en", 64'(replica_en_o), 64'(3'b110));
        chk("t2_deg", 64'(degraded_o), 64'd1);
        chk("t2_nohalt", 64'(halt_req_o), 64'd0);

        // Any fault while degraded is fatal and sticky.
        cyc("t3", 3'b100, 1'b0, 1'b0);
        chk("t3_fatal", 64'(fatal_o), 64'd1);
        repeat (5) cyc("t3_hold", 3'b000, 1'b0, 1'b1);
        chk("t3_sticky", 64'(fatal_o), 64'd1);

        // all_diff during resync.
        do_reset();
        cyc("t4", 3'b100, 1'b0, 1'b0);
        cyc("t4", 3'b000, 1'b0, 1'b1);
        cyc("t4", 3'b000, 1'b0, 1'b0);
        cyc("t4_ad", 3'b000, 1'b1, 1'b0);
        chk("t4_fatal", 64'(fatal_o), 64'd1);
        chk("t4_rs", 64'(resync_o), 64'd0);

        // Double mismatch in IDLE.
        do_reset();
        cyc("t4b", 3'b011, 1'b0, 1'b0);
        chk("t4b_fatal", 64'(fatal_o), 64'd1);

        // Leaky window drains counts back to zero.
        do_reset();
        repeat (3) recover("t5a", 3'b010);
        repeat (3 * WIN) cyc("t5_idle", 3'b000, 1'b0, 1'b0);
        repeat (3) recover("t5b", 3'b010);
        chk("t5_en", 64'(replica_en_o), 64'(3'b111));
        chk("t5_deg", 64'(degraded_o), 64'd0);

        // Asynchronous reset in the middle of a resync.
        do_reset();
        cyc("t6", 3'b100, 1'b0, 1'b0);
        cyc("t6", 3'b000, 1'b0, 1'b1);
        repeat (2) cyc("t6", 3'b000, 1'b0, 1'b0);
        chk("t6_rs", 64'(resync_o), 64'd1);
        do_reset();

        // Random traffic.
        for (int s = 0; s < 3; s++) begin
            do_reset();
            for (int i = 0; i < 2500; i++) begin
                r = $urandom_range(0, 99);
                if (r < 6) mm = 3'(3'b001 << $urandom_range(0, 2));
                else if (r < 8) mm = 3'($urandom);
                else mm = 3'b000;
                cyc("rnd", mm, $urandom_range(0, 399) == 0,
                    $urandom_range(0, 2) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
